// File: rtl/spi_master_ctrl_pkg.sv
// Shared types for the SPI master: FSM state encoding and bus-mode constants.
// This block implements SPI mode 0 only: sck idles low and data is sampled on the rising edge.
package spi_master_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_mstate_t;

  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;

endpackage

// File: rtl/spi_sck_divider.sv
// Purpose: half-period timer; pulses tick for one cycle every CLK_DIV clocks while en is high.
// Latency: the first tick comes CLK_DIV cycles after en rises; the count restarts from 0 after each tick.
// Backpressure: none; the counter clears whenever en is low.
module spi_sck_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Purpose: mode-0 SPI master; sends one word per transfer, MSB first, and captures the word returned on miso.
// Latency: rx_valid is asserted CLK_DIV*(2*DATA_W+2) cycles after acceptance; tx_ready returns CLK_DIV cycles later.
// Backpressure: tx_ready is high only in IDLE; tx_valid seen while busy is dropped, not queued.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  output logic              cs,
  input  logic              miso
);

  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] LAST_HALF = BW'(2 * DATA_W - 1);

  spi_mstate_t       state;
  logic [DATA_W-2:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [BW-1:0]     half_cnt;
  logic              tick;

  spi_sck_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk (clk),
    .rst (rst),
    .en  (state != IDLE),
    .tick(tick)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sck      <= CPOL;
      cs       <= 1'b1;
      mosi     <= 1'b0;
      tx_ready <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      half_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_shift <= tx_data[DATA_W-2:0];
            mosi     <= tx_data[DATA_W-1];
            cs       <= 1'b0;
            tx_ready <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          // First rising edge: MSB has had a full half-period of setup.
          if (tick) begin
            sck      <= 1'b1;
            rx_shift <= {rx_shift[DATA_W-2:0], miso};
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // The final half-period is the low phase after the last fall; sck stays low into HOLD.
          if (tick) begin
            if (half_cnt == LAST_HALF) begin
              half_cnt <= '0;
              state    <= HOLD;
            end else begin
              half_cnt <= half_cnt + 1'b1;
              sck      <= ~sck;
              if (sck) begin
                mosi     <= tx_shift[DATA_W-2];
                tx_shift <= tx_shift << 1;
              end else begin
                rx_shift <= {rx_shift[DATA_W-2:0], miso};
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs       <= 1'b1;
            mosi     <= 1'b0;
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            state    <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            tx_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: randomized and directed transfers against a word-level SPI slave model.
// Expected words and rx_valid cycles are queued at acceptance and popped by the pin monitors.
module tb_spi_master_ctrl;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int LAT  = D * (2 * W + 2);
  localparam int W2   = 16;
  localparam int D2   = 2;
  localparam int LAT2 = D2 * (2 * W2 + 2);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic         tx_valid = 1'b0, tx_ready, rx_valid, busy, sck, mosi, cs, miso;
  logic [W-1:0] tx_data = '0, rx_data;
  logic         loopback = 1'b0, cur_lb = 1'b0, slave_miso = 1'b0;
  logic [W-1:0] resp_word = '0;
  assign miso = cur_lb ? mosi : slave_miso;

  logic          tx_valid2 = 1'b0, tx_ready2, rx_valid2, busy2, sck2, mosi2, cs2, miso2;
  logic [W2-1:0] tx_data2 = '0, rx_data2;
  logic          loop2 = 1'b0;
  assign miso2 = loop2 ? mosi2 : 1'b0;

  spi_master_ctrl #(.DATA_W(W), .CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .sck(sck), .mosi(mosi),
    .cs(cs), .miso(miso)
  );

  spi_master_ctrl #(.DATA_W(W2), .CLK_DIV(D2)) dut2 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_data(tx_data2),
    .rx_valid(rx_valid2), .rx_data(rx_data2), .busy(busy2), .sck(sck2), .mosi(mosi2),
    .cs(cs2), .miso(miso2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { logic [W-1:0]  rx; int due; } exp_t;
  typedef struct { logic [W2-1:0] rx; int due; } exp2_t;
  exp_t         exp_q[$];
  exp2_t        exp2_q[$];
  logic [W-1:0] mosi_q[$];

  // Slave/monitor state for the 8-bit instance.
  logic         p_sck = 1'b0, p_cs = 1'b1, started = 1'b0, rdy_pend = 1'b0, have_gap = 1'b0;
  logic         nxt_lb = 1'b0;
  logic [W-1:0] nxt_rsp = '0, sl_sh = '0, cap = '0;
  int           nrise = 0, rise_cyc = 0, rx_cyc = 0, cs_rise_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      started  = 1'b0;
      rdy_pend = 1'b0;
      have_gap = 1'b0;
    end else begin
      if (tx_valid && tx_ready) begin
        e.rx  = loopback ? tx_data : resp_word;
        e.due = cyc + 1 + LAT;
        exp_q.push_back(e);
        mosi_q.push_back(tx_data);
        nxt_lb  = loopback;
        nxt_rsp = resp_word;
      end
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          chk("rx_valid_unexpected", {31'b0, rx_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", rx_data, e.rx);
          chk("rx_valid_cycle", cyc, e.due);
          rx_cyc   = cyc;
          rdy_pend = 1'b1;
        end
      end else if (rdy_pend && tx_ready) begin
        chk("tx_ready_return", cyc - rx_cyc, D);
        rdy_pend = 1'b0;
      end
      chk("sck_while_deselected", {31'b0, cs && (sck || sck != p_sck)}, 32'd0);
      if (!cs && p_cs) begin
        if (have_gap) chk("cs_deselect_time", {31'b0, (cyc - cs_rise_cyc) >= D}, 32'd1);
        cur_lb     = nxt_lb;
        sl_sh      = nxt_rsp;
        slave_miso = sl_sh[W-1];
        cap        = '0;
        nrise      = 0;
        started    = 1'b1;
      end
      if (sck && !p_sck && !cs) begin
        cap = {cap[W-2:0], mosi};
        if (nrise > 0) chk("sck_period", cyc - rise_cyc, 2 * D);
        rise_cyc = cyc;
        nrise++;
      end
      if (!sck && p_sck && !cs) begin
        sl_sh      = sl_sh << 1;
        slave_miso = sl_sh[W-1];
      end
      if (cs && !p_cs && started) begin
        chk("sck_rise_count", nrise, W);
        if (mosi_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mosi_word unexpected transfer actual=%0h expected=none", cap);
        end else begin
          chk("mosi_word", cap, mosi_q.pop_front());
        end
        cs_rise_cyc = cyc;
        have_gap    = 1'b1;
        started     = 1'b0;
      end
    end
    p_sck = sck;
    p_cs  = cs;
  end

  // Monitor for the 16-bit, CLK_DIV=2 instance.
  logic p_sck2 = 1'b0, p_cs2 = 1'b1, started2 = 1'b0;
  int   n2 = 0, r2 = 0;

  always @(negedge clk) begin
    exp2_t e;
    if (!rst) begin
      started2 = 1'b0;
    end else begin
      if (tx_valid2 && tx_ready2) begin
        e.rx  = loop2 ? tx_data2 : '0;
        e.due = cyc + 1 + LAT2;
        exp2_q.push_back(e);
      end
      if (rx_valid2) begin
        if (exp2_q.size() == 0) begin
          chk("rx2_valid_unexpected", {31'b0, rx_valid2}, 32'd0);
        end else begin
          e = exp2_q.pop_front();
          chk("rx2_data", rx_data2, e.rx);
          chk("rx2_valid_cycle", cyc, e.due);
        end
      end
      if (!cs2 && p_cs2) begin
        n2       = 0;
        started2 = 1'b1;
      end
      if (sck2 && !p_sck2 && !cs2) begin
        if (n2 > 0) chk("sck2_period", cyc - r2, 2 * D2);
        r2 = cyc;
        n2++;
      end
      if (cs2 && !p_cs2 && started2) begin
        chk("sck2_rise_count", n2, W2);
        started2 = 1'b0;
      end
    end
    p_sck2 = sck2;
    p_cs2  = cs2;
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] d, input logic lb, input logic [W-1:0] rsp, input logic keep);
    int n = 0;
    tx_data   = d;
    loopback  = lb;
    resp_word = rsp;
    tx_valid  = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_ready) break;
      n++;
      if (n > 500) break;
    end
    chk("send_accept_bound", {31'b0, n <= 500}, 32'd1);
    @(posedge clk);
    #1;
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !tx_ready) && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("wait_idle_bound", {31'b0, n < 2000}, 32'd1);
  endtask

  task automatic send2(input logic [W2-1:0] d, input logic lb);
    int n = 0;
    tx_data2  = d;
    loop2     = lb;
    tx_valid2 = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_ready2) break;
      n++;
      if (n > 500) break;
    end
    chk("send2_accept_bound", {31'b0, n <= 500}, 32'd1);
    @(posedge clk);
    #1;
    tx_valid2 = 1'b0;
    n = 0;
    while ((exp2_q.size() != 0 || !tx_ready2) && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("wait_idle2_bound", {31'b0, n < 2000}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset_cs", cs, 1);
    chk("reset_sck", sck, 0);
    chk("reset_mosi", mosi, 0);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_busy2", busy2, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send(8'hA5, 1'b1, 8'h00, 1'b0);
    chk("busy_during_transfer", busy, 1);
    chk("tx_ready_during_transfer", tx_ready, 0);
    wait_idle();
    send(8'hC3, 1'b0, 8'h3C, 1'b0);
    wait_idle();
    send(8'h01, 1'b1, 8'h00, 1'b1);
    send(8'h80, 1'b1, 8'h00, 1'b0);
    wait_idle();

    send(8'h11, 1'b0, 8'h96, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    chk("tx_ready_while_busy", tx_ready, 0);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    wait_idle();

    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] d, r;
      logic         lb, kp;
      d  = W'($urandom);
      r  = W'($urandom);
      lb = 1'($urandom_range(0, 1));
      kp = (i < 11) && ($urandom_range(0, 2) == 0);
      send(d, lb, r, kp);
      if (!kp && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 100)) @(posedge clk);
        #1;
      end
    end
    wait_idle();

    send(8'h96, 1'b1, 8'h00, 1'b0);
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_cs", cs, 1);
    chk("abort_sck", sck, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rx_valid", rx_valid, 0);
    exp_q.delete();
    mosi_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(8'h5A, 1'b1, 8'h00, 1'b0);
    wait_idle();
    send(8'h6B, 1'b0, 8'hE7, 1'b0);
    wait_idle();

    send2(16'hFFFF, 1'b0);
    send2(16'($urandom), 1'b1);
    send2(16'($urandom), 1'b1);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
